jtag_emu_shifter: RTL and testbench



---
 rtl/jtag_emu_pkg.sv | 28 ++
 rtl/jtag_emu_tck_div.sv | 36 +++
 rtl/jtag_emu_shifter.sv | 189 ++++++++++++++++++
 tb/tb_jtag_emu_shifter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_emu_pkg.sv
// ----------------------------------------------------------------------------
// jtag_emu_pkg
// Shared definitions for the jtag_emu hardware shift engine: FSM state type,
// command field widths and a helper that clamps a requested bit count to the
// maximum command size.
// ----------------------------------------------------------------------------
package jtag_emu_pkg;

    localparam int unsigned JTAG_LEN_W  = 6;
    localparam int unsigned JTAG_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        TRST,
        RESP
    } jtag_state_t;

    // Requests longer than one data word shift a full word and no more.
    function automatic logic [JTAG_LEN_W-1:0] clamp_len(input logic [JTAG_LEN_W-1:0] len);
        if (len > JTAG_LEN_W'(JTAG_DATA_W)) begin
            return JTAG_LEN_W'(JTAG_DATA_W);
        end
        return len;
    endfunction

endpackage

// File: rtl/jtag_emu_tck_div.sv
// ----------------------------------------------------------------------------
// jtag_emu_tck_div
// Half-period counter for the generated TCK. Reloads on entry to every phase
// and flags the final clk cycle of the phase.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   load         a new phase starts on the next cycle (reload the counter)
//   active       FSM is in a timed phase (LOW, HIGH or TRST)
//   phase_end_o  high on the last cycle of the current phase
// ----------------------------------------------------------------------------
module jtag_emu_tck_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic active,
    output logic phase_end_o
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= 8'(CLK_DIV - 1);
        end else if (count != '0) begin
            count <= count - 8'd1;
        end
    end

    assign phase_end_o = active && (count == '0);

endmodule

// File: rtl/jtag_emu_shifter.sv
// ----------------------------------------------------------------------------
// jtag_emu_shifter
// Hardware JTAG shift engine. Accepts one command of up to 32 TMS/TDI bit
// pairs (or a TRST pulse), generates TCK from clk, captures TDO on the last
// cycle of each TCK-high phase and returns the captured word through a
// valid/ready response.
//
// Ports:
//   clk, rst_n                        system clock, async active-low reset
//   cmd_valid_i / cmd_ready_o         command handshake (ready == idle)
//   cmd_len_i                         bit count, 0 = no shift, >32 clamps to 32
//   cmd_tms_i, cmd_tdi_i              bit pairs, bit 0 shifted first
//   cmd_trst_i                        perform a TRST pulse instead of a shift
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_tdo_o                         captured TDO, bit i from shift i
//   tck_o, trstn_o, tms_o, tdi_o      registered TAP drive
//   tdo_i                             TAP data out
//   busy_o                            high whenever not idle
//
// Build option:
//   JTAG_TDO_SYNC_EN  route tdo_i through a 2-flop synchronizer (needs
//                     CLK_DIV >= 3); otherwise tdo_i is sampled directly.
// ----------------------------------------------------------------------------
module jtag_emu_shifter
    import jtag_emu_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [JTAG_LEN_W-1:0] cmd_len_i,
    input  logic [DATA_W-1:0]     cmd_tms_i,
    input  logic [DATA_W-1:0]     cmd_tdi_i,
    input  logic                  cmd_trst_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_tdo_o,
    output logic                  tck_o,
    output logic                  trstn_o,
    output logic                  tms_o,
    output logic                  tdi_o,
    input  logic                  tdo_i,
    output logic                  busy_o
);

    jtag_state_t           state;
    jtag_state_t           state_next;
    logic [JTAG_LEN_W-1:0] len_q;
    logic [JTAG_LEN_W-1:0] bit_cnt;
    logic [DATA_W-1:0]     tms_sh;
    logic [DATA_W-1:0]     tdi_sh;
    logic                  trst_half;
    logic                  accept;
    logic                  last_bit;
    logic                  phase_end;
    logic                  tdo_s;

    // ------------------------------------------------------------------
    // TDO capture path
    // ------------------------------------------------------------------
`ifdef JTAG_TDO_SYNC_EN
    if (CLK_DIV < 3) begin : g_div_too_small
        $error("jtag_emu_shifter: JTAG_TDO_SYNC_EN requires CLK_DIV >= 3");
    end

    logic [1:0] tdo_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo_sync <= '0;
        end else begin
            tdo_sync <= {tdo_sync[0], tdo_i};
        end
    end

    assign tdo_s = tdo_sync[1];
`else
    assign tdo_s = tdo_i;
`endif

    // ------------------------------------------------------------------
    // Phase timer
    // ------------------------------------------------------------------
    jtag_emu_tck_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (accept || phase_end),
        .active      (state inside {LOW, HIGH, TRST}),
        .phase_end_o (phase_end)
    );

    assign accept   = cmd_valid_i && (state == IDLE);
    assign last_bit = (bit_cnt + JTAG_LEN_W'(1)) == len_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_trst_i) begin
                        state_next = TRST;
                    end else if (cmd_len_i == '0) begin
                        state_next = RESP;
                    end else begin
                        state_next = LOW;
                    end
                end
            end
            LOW:  if (phase_end) state_next = HIGH;
            HIGH: if (phase_end) state_next = last_bit ? RESP : LOW;
            // TRST spans two timer phases, so the 8-bit timer covers 2*CLK_DIV.
            TRST: if (phase_end && trst_half) state_next = RESP;
            RESP: if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign rsp_valid_o = (state == RESP);

    // ------------------------------------------------------------------
    // Datapath and registered TAP outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            bit_cnt   <= '0;
            tms_sh    <= '0;
            tdi_sh    <= '0;
            trst_half <= 1'b0;
            rsp_tdo_o <= '0;
            tck_o     <= 1'b0;
            trstn_o   <= 1'b0;
            tms_o     <= 1'b1;
            tdi_o     <= 1'b0;
        end else begin
            // Driving the TAP pins from the next state keeps them registered
            // while still lining up with the state they belong to.
            tck_o   <= (state_next == HIGH);
            trstn_o <= (state_next != TRST);

            if (accept) begin
                len_q     <= clamp_len(cmd_len_i);
                bit_cnt   <= '0;
                trst_half <= 1'b0;
                rsp_tdo_o <= '0;
                tms_sh    <= cmd_tms_i >> 1;
                tdi_sh    <= cmd_tdi_i >> 1;
                if (!cmd_trst_i && (cmd_len_i != '0)) begin
                    tms_o <= cmd_tms_i[0];
                    tdi_o <= cmd_tdi_i[0];
                end
            end

            if ((state == TRST) && phase_end) begin
                trst_half <= 1'b1;
            end

            if ((state == HIGH) && phase_end) begin
                rsp_tdo_o[bit_cnt[4:0]] <= tdo_s;
                bit_cnt                 <= bit_cnt + JTAG_LEN_W'(1);
                if (!last_bit) begin
                    tms_o  <= tms_sh[0];
                    tdi_o  <= tdi_sh[0];
                    tms_sh <= tms_sh >> 1;
                    tdi_sh <= tdi_sh >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_emu_shifter.sv
// ----------------------------------------------------------------------------
// tb_jtag_emu_shifter
// Self-checking bench for jtag_emu_shifter: directed vector table, hand-written
// TRST/len0/stall/reset sequences and randomized commands checked against a
// transaction-level model of the shift engine.
// ----------------------------------------------------------------------------
module tb_jtag_emu_shifter;

    localparam int unsigned D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [5:0]  cmd_len_i = '0;
    logic [31:0] cmd_tms_i = '0;
    logic [31:0] cmd_tdi_i = '0;
    logic        cmd_trst_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_tdo_o;
    logic        tck_o, trstn_o, tms_o, tdi_o;
    logic        tdo_i = 1'b0;
    logic        busy_o;

    jtag_emu_shifter #(
        .CLK_DIV (D),
        .DATA_W  (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .cmd_tms_i   (cmd_tms_i),
        .cmd_tdi_i   (cmd_tdi_i),
        .cmd_trst_i  (cmd_trst_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_tdo_o   (rsp_tdo_o),
        .tck_o       (tck_o),
        .trstn_o     (trstn_o),
        .tms_o       (tms_o),
        .tdi_o       (tdi_o),
        .tdo_i       (tdo_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic        trst;
        logic [5:0]  len;
        logic [31:0] tms;
        logic [31:0] tdi;
        logic [31:0] tdo_w;
        logic        loopback;
        int unsigned stall;
        logic [31:0] exp_data;
        int unsigned exp_pulses;
        int unsigned exp_lat;
        int unsigned exp_trst_low;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one command and follows it to the response handshake, checking
    // TAP waveform, latency, captured data and response hold behaviour.
    task automatic do_cmd(input vec_t v, input string tag);
        int unsigned w;
        int unsigned lat;
        int unsigned rises;
        int unsigned highs;
        int unsigned tlow;
        int unsigned seq_err;
        int unsigned stall_err;
        logic        prev_tck;
        logic        hold_tms;
        logic        hold_tdi;
        logic [31:0] held_data;

        w = 0;
        while (!cmd_ready_o && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " cmd_ready"}, 32'(cmd_ready_o), 32'd1);

        cmd_valid_i = 1'b1;
        cmd_trst_i  = v.trst;
        cmd_len_i   = v.len;
        cmd_tms_i   = v.tms;
        cmd_tdi_i   = v.tdi;

        lat = 0; rises = 0; highs = 0; tlow = 0; seq_err = 0;
        prev_tck = 1'b0; hold_tms = 1'b0; hold_tdi = 1'b0;
        for (int unsigned c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Command fields are latched; scrambling them must not matter.
                cmd_valid_i = 1'b0;
                cmd_tms_i   = $urandom;
                cmd_tdi_i   = $urandom;
                cmd_len_i   = 6'($urandom);
                cmd_trst_i  = 1'($urandom);
            end
            if (tck_o && !prev_tck) begin
                if (rises < 32) begin
                    if (tms_o !== v.tms[rises] || tdi_o !== v.tdi[rises]) seq_err++;
                    tdo_i = v.loopback ? tdi_o : v.tdo_w[rises];
                end
                rises++;
                hold_tms = tms_o;
                hold_tdi = tdi_o;
            end else if (tck_o && (tms_o !== hold_tms || tdi_o !== hold_tdi)) begin
                seq_err++;
            end
            if (tck_o) highs++;
            if (!trstn_o) begin
                tlow++;
                if (tck_o) seq_err++;
            end
            prev_tck = tck_o;
            if (rsp_valid_o) begin
                lat = c;
                break;
            end
        end

        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " tck_pulses"}, 32'(rises), 32'(v.exp_pulses));
        chk({tag, " tck_high_cycles"}, 32'(highs), 32'(v.exp_pulses * D));
        chk({tag, " trst_low_cycles"}, 32'(tlow), 32'(v.exp_trst_low));
        chk({tag, " tms_tdi_sequence_errors"}, 32'(seq_err), 32'd0);
        chk({tag, " rsp_tdo"}, rsp_tdo_o, v.exp_data);
        chk({tag, " resp_tck_low_busy"}, {30'd0, tck_o, busy_o}, 32'd1);

        // Stall with a competing command held valid.
        held_data = rsp_tdo_o;
        stall_err = 0;
        for (int unsigned s = 0; s < v.stall; s++) begin
            cmd_valid_i = 1'b1;
            cmd_len_i   = 6'd3;
            @(negedge clk);
            if (!rsp_valid_o || cmd_ready_o || rsp_tdo_o !== held_data || tck_o) stall_err++;
        end
        if (v.stall > 0) chk({tag, " stall_hold_errors"}, 32'(stall_err), 32'd0);

        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk({tag, " back_to_idle"}, {30'd0, cmd_ready_o, rsp_valid_o}, 32'd2);
        tdo_i = 1'b0;
    endtask

    // Transaction-level expectation of a command.
    function automatic vec_t model(input logic trst, input logic [5:0] len, input logic [31:0] tms,
                                   input logic [31:0] tdi, input logic [31:0] tdo_w, input int unsigned stall);
        vec_t        v;
        int unsigned n;
        logic [63:0] mask;
        n = (len > 32) ? 32 : int'(len);
        mask = (64'd1 << n) - 64'd1;
        v.trst = trst; v.len = len; v.tms = tms; v.tdi = tdi; v.tdo_w = tdo_w;
        v.loopback = 1'b0; v.stall = stall;
        v.exp_data     = trst ? 32'd0 : (tdo_w & mask[31:0]);
        v.exp_pulses   = trst ? 0 : n;
        v.exp_lat      = trst ? 2 * D + 1 : 1 + 2 * n * D;
        v.exp_trst_low = trst ? 2 * D : 0;
        return v;
    endfunction

    initial begin
        int unsigned w;
        int unsigned rises;
        logic        prev_tck;
        vec_t        rv;

        //          trst  len     tms           tdi           tdo_w         loop  stall exp_data      pulses lat  tlow
        vecs[0] = '{1'b0, 6'd5,  32'h0000_001F, 32'h0000_0000, 32'h0000_0000, 1'b0, 0,  32'h0000_0000, 5,  21,  0};
        vecs[1] = '{1'b0, 6'd32, 32'h0F0F_3C3C, 32'hA5C3_0F1E, 32'h0000_0000, 1'b1, 2,  32'hA5C3_0F1E, 32, 129, 0};
        vecs[2] = '{1'b0, 6'd8,  32'h0000_0055, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b0, 0,  32'h0000_00FF, 8,  33,  0};
        vecs[3] = '{1'b0, 6'd40, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 1'b0, 1,  32'hFFFF_FFFF, 32, 129, 0};
        vecs[4] = '{1'b1, 6'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0,  32'h0000_0000, 0,  5,   4};
        vecs[5] = '{1'b0, 6'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10, 32'h0000_0000, 0,  1,   0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset tap {tck,trstn,tms,tdi}", {28'd0, tck_o, trstn_o, tms_o, tdi_o}, 32'h2);
        chk("reset {rsp_valid,busy,cmd_ready}", {29'd0, rsp_valid_o, busy_o, cmd_ready_o}, 32'h1);
        chk("reset rsp_tdo", rsp_tdo_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("trstn after reset release", 32'(trstn_o), 32'd1);

        // Directed table: basic shift, loopback, ones, clamp, TRST, len0 with stall
        for (int i = 0; i < 6; i++) begin
            do_cmd(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during bit 3 of a 16-bit shift
        w = 0;
        while (!cmd_ready_o && w < 300) begin
            @(negedge clk);
            w++;
        end
        cmd_valid_i = 1'b1; cmd_trst_i = 1'b0; cmd_len_i = 6'd16;
        cmd_tms_i = 32'h0000_A5A5; cmd_tdi_i = 32'h0000_5A5A;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        rises = 0; prev_tck = 1'b0; w = 0;
        while (!(rises == 3 && !tck_o) && w < 200) begin
            if (tck_o && !prev_tck) rises++;
            prev_tck = tck_o;
            @(negedge clk);
            w++;
        end
        chk("reach bit 3 of 16", 32'(rises), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset tap {tck,trstn,tms,tdi}", {28'd0, tck_o, trstn_o, tms_o, tdi_o}, 32'h2);
        chk("midreset {rsp_valid,busy,cmd_ready}", {29'd0, rsp_valid_o, busy_o, cmd_ready_o}, 32'h1);
        chk("midreset rsp_tdo", rsp_tdo_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rv = model(1'b0, 6'd16, 32'h0000_C3C3, 32'h0000_F00F, 32'h1234_BEEF, 0);
        do_cmd(rv, "post_reset16");

        // Randomized commands against the model
        for (int i = 0; i < 25; i++) begin
            rv = model(($urandom_range(0, 9) == 0), 6'($urandom_range(0, 40)), $urandom, $urandom,
                       $urandom, $urandom_range(0, 3));
            do_cmd(rv, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
